// File: rtl/alu_operand_loader_pkg.sv
// Shared defaults, types and helpers for the ALU operand loader slice.
package alu_bench_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_OP_W     = 5;
  localparam int DEBOUNCE_SIM = 4;

  typedef logic [DEF_DATA_W-1:0] operand_t;

  // Width needed to index n items, never below one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle for the loader: raw keys/switches in, operand bank state out.
interface alu_operand_loader_if
  import alu_bench_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 4,
  parameter int OP_W     = DEF_OP_W
);
  localparam int SEL_W = sel_w(NUM_REGS);

  logic                       KEY_NEXT_N;
  logic                       KEY_LOAD_N;
  logic [DATA_W-1:0]          SW;
  logic [SEL_W-1:0]           reg_sel;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [OP_W-1:0]            op_code;
  logic [NUM_REGS-1:0]        written;
  logic                       load_pulse;

  modport master (
    output KEY_NEXT_N, KEY_LOAD_N, SW,
    input  reg_sel, regs_flat, op_code, written, load_pulse
  );

  modport slave (
    input  KEY_NEXT_N, KEY_LOAD_N, SW,
    output reg_sel, regs_flat, op_code, written, load_pulse
  );
endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// Pushbutton conditioner: 2-FF sync, stability counter, one-cycle press strobe on 1->0.
module key_debounce
  import alu_bench_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);
  localparam int CNT_W = sel_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // The strobe is raised on the same edge the level falls, so no separate edge flop is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], raw_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;
endmodule

// File: rtl/alu_operand_loader.sv
// Operand bank for board-level ALU testing; define ALU_LOADER_AUTOINC_EN to
// advance the register select on every load as well as on NEXT presses.
module alu_operand_loader
  import alu_bench_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int NUM_REGS        = 4,
  parameter int OP_W            = DEF_OP_W,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  alu_operand_loader_if.slave  bus
);
  localparam int SEL_W = sel_w(NUM_REGS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

  logic                w_next_evt;
  logic                w_load_evt;
  logic                w_advance;
  logic [SEL_W-1:0]    w_sel_next;
  logic [DATA_W-1:0]   r_sw_meta;
  logic [DATA_W-1:0]   r_sw_sync;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_written;
  logic                r_load_pulse;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .raw_n (bus.KEY_NEXT_N),
    .press (w_next_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .raw_n (bus.KEY_LOAD_N),
    .press (w_load_evt)
  );

  // Simultaneous load and next still collapse into a single advance.
  always_comb begin
    w_advance = w_next_evt;
`ifdef ALU_LOADER_AUTOINC_EN
    w_advance = w_next_evt | w_load_evt;
`else
    w_advance = w_next_evt;
`endif
    w_sel_next = (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= bus.SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sel        <= '0;
      r_written    <= '0;
      r_load_pulse <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_load_pulse <= w_load_evt;
      if (w_advance) begin
        r_sel <= w_sel_next;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_load_evt && (r_sel == SEL_W'(i))) begin
          r_regs[i]    <= r_sw_sync;
          r_written[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign bus.reg_sel    = r_sel;
  assign bus.op_code    = r_regs[0][OP_W-1:0];
  assign bus.written    = r_written;
  assign bus.load_pulse = r_load_pulse;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench: a 4-register and a 3-register loader driven side by side (debounce = 4).
module tb_alu_operand_loader;
   import alu_bench_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pulse4 = 0;
   int   max_sel3 = 0;
   int   base;

   alu_operand_loader_if #(.DATA_W(16), .NUM_REGS(4), .OP_W(5)) bus4 ();
   alu_operand_loader_if #(.DATA_W(16), .NUM_REGS(3), .OP_W(5)) bus3 ();

   alu_operand_loader #(.DATA_W(16), .NUM_REGS(4), .OP_W(5), .DEBOUNCE_CYCLES(DEBOUNCE_SIM)) u_dut4 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus4)
   );

   alu_operand_loader #(.DATA_W(16), .NUM_REGS(3), .OP_W(5), .DEBOUNCE_CYCLES(DEBOUNCE_SIM)) u_dut3 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus3)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus4.load_pulse) n_pulse4 <= n_pulse4 + 1;
      if (int'(bus3.reg_sel) > max_sel3) max_sel3 <= int'(bus3.reg_sel);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hold the chosen keys low long enough to debounce, then release and let it settle.
   task automatic press(input logic ld, input logic nx);
      @(negedge clk);
      bus4.KEY_LOAD_N = ~ld;
      bus4.KEY_NEXT_N = ~nx;
      bus3.KEY_NEXT_N = ~nx;
      repeat (10) @(negedge clk);
      bus4.KEY_LOAD_N = 1'b1;
      bus4.KEY_NEXT_N = 1'b1;
      bus3.KEY_NEXT_N = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [1:0] wrap4 [4];
      logic [1:0] wrap3 [4];
      wrap4 = '{2'd1, 2'd2, 2'd3, 2'd0};
      wrap3 = '{2'd1, 2'd2, 2'd0, 2'd1};

      rst_n           = 1'b0;
      bus4.KEY_LOAD_N = 1'b1;
      bus4.KEY_NEXT_N = 1'b1;
      bus4.SW         = '0;
      bus3.KEY_LOAD_N = 1'b1;
      bus3.KEY_NEXT_N = 1'b1;
      bus3.SW         = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset: load something, start a debounce, then assert reset mid-cycle.
      bus4.SW = 16'h1234;
      press(1'b1, 1'b0);
      @(negedge clk);
      bus4.KEY_LOAD_N = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sel",   64'(bus4.reg_sel),    64'h0);
      chk("rst_regs",  64'(bus4.regs_flat),  64'h0);
      chk("rst_wr",    64'(bus4.written),    64'h0);
      chk("rst_op",    64'(bus4.op_code),    64'h0);
      chk("rst_pulse", 64'(bus4.load_pulse), 64'h0);
      bus4.KEY_LOAD_N = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      base = n_pulse4;
      repeat (10) @(negedge clk);
      chk("idle_regs",  64'(bus4.regs_flat), 64'h0);
      chk("idle_wr",    64'(bus4.written),   64'h0);
      chk("idle_sel",   64'(bus4.reg_sel),   64'h0);
      chk("idle_pulse", 64'(n_pulse4 - base), 64'd0);

      // Load and step.
      bus4.SW = 16'h0012;
      base = n_pulse4;
      press(1'b1, 1'b0);
      chk("ld0_regs",  64'(bus4.regs_flat), 64'h0000_0000_0000_0012);
      chk("ld0_op",    64'(bus4.op_code),   64'h12);
      chk("ld0_wr",    64'(bus4.written),   64'h1);
      chk("ld0_pulse", 64'(n_pulse4 - base), 64'd1);
`ifdef ALU_LOADER_AUTOINC_EN
      chk("ld0_sel",   64'(bus4.reg_sel),   64'd1);
`else
      chk("ld0_sel",   64'(bus4.reg_sel),   64'd0);
`endif
      press(1'b0, 1'b1);
      bus4.SW = 16'hBEEF;
      press(1'b1, 1'b0);
`ifdef ALU_LOADER_AUTOINC_EN
      chk("ld1_regs", 64'(bus4.regs_flat), 64'h0000_BEEF_0000_0012);
      chk("ld1_sel",  64'(bus4.reg_sel),   64'd3);
      chk("ld1_wr",   64'(bus4.written),   64'h5);
`else
      chk("ld1_regs", 64'(bus4.regs_flat), 64'h0000_0000_BEEF_0012);
      chk("ld1_sel",  64'(bus4.reg_sel),   64'd1);
      chk("ld1_wr",   64'(bus4.written),   64'h3);
`endif

      // Bounce then hold: exactly one write.
      bus4.SW = 16'h00A5;
      base = n_pulse4;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         bus4.KEY_LOAD_N = ~bus4.KEY_LOAD_N;
         repeat (2) @(negedge clk);
      end
      press(1'b1, 1'b0);
      chk("bnc_pulse", 64'(n_pulse4 - base), 64'd1);
`ifdef ALU_LOADER_AUTOINC_EN
      chk("bnc_regs", 64'(bus4.regs_flat), 64'h00A5_BEEF_0000_0012);
`else
      chk("bnc_regs", 64'(bus4.regs_flat), 64'h0000_0000_00A5_0012);
`endif
      // Three-cycle glitch: ignored.
      bus4.SW = 16'h7777;
      base = n_pulse4;
      @(negedge clk);
      bus4.KEY_LOAD_N = 1'b0;
      repeat (3) @(negedge clk);
      bus4.KEY_LOAD_N = 1'b1;
      repeat (12) @(negedge clk);
      chk("glt_pulse", 64'(n_pulse4 - base), 64'd0);
`ifdef ALU_LOADER_AUTOINC_EN
      chk("glt_regs", 64'(bus4.regs_flat), 64'h00A5_BEEF_0000_0012);
`else
      chk("glt_regs", 64'(bus4.regs_flat), 64'h0000_0000_00A5_0012);
`endif

      // Select wrap on 4 and 3 registers.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         press(1'b0, 1'b1);
         chk($sformatf("wrap4_%0d", i), 64'(bus4.reg_sel), 64'(wrap4[i]));
         chk($sformatf("wrap3_%0d", i), 64'(bus3.reg_sel), 64'(wrap3[i]));
      end
      chk("wrap3_max", 64'(max_sel3), 64'd2);

      // Simultaneous load and next at reg_sel=2.
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      chk("sim_pre_sel", 64'(bus4.reg_sel), 64'd2);
      bus4.SW = 16'hC3C3;
      press(1'b1, 1'b1);
      chk("sim_regs",  64'(bus4.regs_flat), 64'h0000_C3C3_0000_0000);
      chk("sim_sel",   64'(bus4.reg_sel),   64'd3);
      chk("sim_wr",    64'(bus4.written),   64'h4);
      chk("sim_sel3",  64'(bus3.reg_sel),   64'd1);

      // Five back-to-back loads with SW = 1..5.
      do_reset();
      base = n_pulse4;
      for (int v = 1; v <= 5; v++) begin
         bus4.SW = operand_t'(v);
         press(1'b1, 1'b0);
      end
      chk("ai_pulse", 64'(n_pulse4 - base), 64'd5);
`ifdef ALU_LOADER_AUTOINC_EN
      chk("ai_regs", 64'(bus4.regs_flat), 64'h0004_0003_0002_0005);
      chk("ai_sel",  64'(bus4.reg_sel),   64'd1);
      chk("ai_wr",   64'(bus4.written),   64'hF);
`else
      chk("ai_regs", 64'(bus4.regs_flat), 64'h0000_0000_0000_0005);
      chk("ai_sel",  64'(bus4.reg_sel),   64'd0);
      chk("ai_wr",   64'(bus4.written),   64'h1);
`endif
      chk("ai_op", 64'(bus4.op_code), 64'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
